uart_tx_out: RTL and testbench
==============================

Name: uart_tx_out

Overview:
- Memory-mapped UART transmitter. Sits downstream of the processor store path, alongside the parallel output port.
- Consumes the same store bus: register data, ULA address and the MemWrite enable.
- Buffers bytes in a small FIFO and serialises them 8N1 onto UART_TXD.
- Returns a status byte that the input mux can route back to the register file.

Parameters:
CLK_HZ, 50000000, frequency of clk in Hz
BAUD, 115200, line rate; DIV = CLK_HZ/BAUD (integer truncation), must be >= 2
FIFO_DEPTH, 8, TX FIFO entries; power of two, range 2..16
TX_ADDR, 8'hFC, store address that pushes a byte into the FIFO
STAT_ADDR, 8'hFD, address of the status register; a store here clears overflow

Ports:
clk  input  1  system clock (CLOCK_50 domain); all logic rising-edge
rst  input  1  synchronous, active-high reset
RegData  input  8  store data (rd2)
Address  input  8  store/load address (ULAResult)
EN  input  1  write enable (MemWrite)
UART_TXD  output  1  serial line; idle high
Status  output  8  {1'b0, count[3:0], overflow, full, busy}
Last_Byte  output  8  last byte accepted into the FIFO

Behaviour:
- Reset values (rst high at an edge): UART_TXD=1, FIFO empty (count=0), overflow=0, busy=0, full=0, Last_Byte=8'h00, FSM=IDLE, baud counter=0.
- Reset mid-frame aborts the frame. TXD is 1 from the next edge. Pending bytes are discarded.
- Push condition: EN && Address==TX_ADDR && !full. On push, RegData is written at the tail and Last_Byte<=RegData.
- full is evaluated on pre-edge state. A push while full is dropped even if a pop occurs in the same cycle, and overflow<=1.
- overflow is sticky. It is cleared only by EN && Address==STAT_ADDR (data ignored) or by rst. Clear wins over a same-cycle set.
- count ranges 0..FIFO_DEPTH. full = (count==FIFO_DEPTH). A simultaneous push and pop leaves count unchanged.
- busy = (FSM!=IDLE) || (count!=0). Status is combinational from registered state.
- FSM states:
  - IDLE: TXD=1. If count!=0, pop the head into the shift register, load the baud counter, set TXD<=0 and go to START.
  - START: hold 0 for DIV clks, then go to DATA with bit index 0.
  - DATA: drive shift[0], LSB first. Each bit lasts DIV clks. After bit 7, go to STOP.
  - STOP: hold 1 for DIV clks. At the end of the stop bit, if count!=0, pop and enter START directly (no idle gap); otherwise go to IDLE.
- Latency: a push at edge t with an idle, empty FIFO gives a start-bit edge at t+1. A frame is exactly 10*DIV clks.
- Baud counter counts 0..DIV-1. Bit boundaries occur when the counter reaches DIV-1. It is free of drift across back-to-back frames.
- Push into an empty FIFO in the same cycle the FSM samples empty: the byte is popped on the following cycle.

Optional Feature:
- Macro: UART_WR_EDGE_EN.
- When defined:
  - A write is recognised only on the rising edge of the qualified write (EN && address match), using a registered previous value that resets to 0.
  - This yields one push per store even when the processor's hand clock holds EN high for many clk cycles.
  - The same rule applies to the STAT_ADDR clear.
  - Push latency is unchanged: the edge is detected in the first high cycle.
- When undefined: every clk cycle with the qualified write high is a separate write.

Test Plan:
1. Reset with CLK_HZ=8, BAUD=1 (DIV=8) -> UART_TXD=1, Status=8'h00, Last_Byte=8'h00.
2. Single write of 8'hA5 to 8'hFC at edge t -> TXD=0 over t+1..t+8, then bits 1,0,1,0,0,1,0,1 (8 clks each), then stop=1. busy drops at t+81. Last_Byte=8'hA5.
3. Ten consecutive writes of 8'h00..8'h09 starting from idle -> 8'h09 dropped, count=8 after the 10th cycle, overflow=1. Nine contiguous frames 8'h00..8'h08 follow, totalling 720 clks with no idle gap.
4. Overflow set, then a write to 8'hFD -> Status[2]=0 next cycle; count and transmission unaffected.
5. rst asserted in DATA bit 3 with 3 bytes queued -> next cycle TXD=1 and Status=0; no further frames.
6. EN held high for 20 clks at 8'hFC with data 8'h3C:
   - with UART_WR_EDGE_EN: exactly one frame, count never exceeds 1, overflow=0.
   - without it: FIFO fills to 8 and overflow=1.

Source files
------------

// File: rtl/uart_tx_out.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a status register.
// Define UART_WR_EDGE_EN to accept only the rising edge of each qualified write.
module uart_tx_out #(
  parameter int         CLK_HZ     = 50000000,
  parameter int         BAUD       = 115200,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] TX_ADDR    = 8'hFC,
  parameter logic [7:0] STAT_ADDR  = 8'hFD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] RegData,
  input  logic [7:0] Address,
  input  logic       EN,
  output logic       UART_TXD,
  output logic [7:0] Status,
  output logic [7:0] Last_Byte
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] CNT_ZERO  = NW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   baud_r, baud_s;
  logic [2:0]      bit_r, bit_s;
  logic [7:0]      shift_r, shift_s;
  logic            txd_r, txd_s;
  logic            pop_s;

  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]   head_r, tail_r;
  logic [NW-1:0]   count_r;
  logic            overflow_r;
  logic [7:0]      last_byte_r;

  logic            wr_tx_q_s, wr_stat_q_s, wr_tx_s, wr_stat_s;
  logic            full_s, push_s, busy_s, baud_end_s, pending_s;

  assign wr_tx_q_s   = EN && (Address == TX_ADDR);
  assign wr_stat_q_s = EN && (Address == STAT_ADDR);

`ifdef UART_WR_EDGE_EN
  logic wr_tx_prev_r, wr_stat_prev_r;

  // Previous qualified-write levels for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_tx_prev_r   <= 1'b0;
      wr_stat_prev_r <= 1'b0;
    end else begin
      wr_tx_prev_r   <= wr_tx_q_s;
      wr_stat_prev_r <= wr_stat_q_s;
    end
  end

  assign wr_tx_s   = wr_tx_q_s && !wr_tx_prev_r;
  assign wr_stat_s = wr_stat_q_s && !wr_stat_prev_r;
`else
  assign wr_tx_s   = wr_tx_q_s;
  assign wr_stat_s = wr_stat_q_s;
`endif

  assign full_s     = (count_r == CNT_FULL);
  assign push_s     = wr_tx_s && !full_s;
  assign pending_s  = (count_r != CNT_ZERO);
  assign busy_s     = (state_r != IDLE) || pending_s;
  assign baud_end_s = (baud_r == BAUD_LAST);

  assign UART_TXD  = txd_r;
  assign Last_Byte = last_byte_r;
  assign Status    = {1'b0, 4'(count_r), overflow_r, full_s, busy_s};

  // Next-state and datapath for the serialiser; STOP chains straight into START
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    txd_s   = txd_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        txd_s = 1'b1;
        if (pending_s) begin
          pop_s   = 1'b1;
          shift_s = mem_r[head_r];
          baud_s  = {CW{1'b0}};
          txd_s   = 1'b0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          baud_s  = {CW{1'b0}};
          bit_s   = 3'd0;
          txd_s   = shift_r[0];
          state_s = DATA;
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_s = {CW{1'b0}};
          if (bit_r == 3'd7) begin
            txd_s   = 1'b1;
            state_s = STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            txd_s   = shift_r[1];
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_s = {CW{1'b0}};
          if (pending_s) begin
            pop_s   = 1'b1;
            shift_s = mem_r[head_r];
            txd_s   = 1'b0;
            state_s = START;
          end else begin
            txd_s   = 1'b1;
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        baud_s  = {CW{1'b0}};
        txd_s   = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Serialiser state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      baud_r  <= {CW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      txd_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      txd_r   <= txd_s;
    end
  end

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[tail_r] <= RegData;
    end else begin
      mem_r[tail_r] <= mem_r[tail_r];
    end
  end

  // FIFO pointers, occupancy, sticky overflow and last accepted byte
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r      <= {PW{1'b0}};
      tail_r      <= {PW{1'b0}};
      count_r     <= CNT_ZERO;
      overflow_r  <= 1'b0;
      last_byte_r <= 8'h00;
    end else begin
      if (push_s) begin
        tail_r      <= tail_r + PTR_ONE;
        last_byte_r <= RegData;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      count_r <= count_r + NW'(push_s) - NW'(pop_s);
      if (wr_stat_s) begin
        overflow_r <= 1'b0;
      end else if (wr_tx_s && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_out.sv
// Directed self-checking bench for uart_tx_out with DIV = 8 (CLK_HZ=8, BAUD=1).
// Expectations for the held-EN test follow UART_WR_EDGE_EN when it is defined.
module tb_uart_tx_out;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] RegData;
  logic [7:0] Address;
  logic       EN;
  logic       UART_TXD;
  logic [7:0] Status;
  logic [7:0] Last_Byte;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_out #(
    .CLK_HZ    (8),
    .BAUD      (1),
    .FIFO_DEPTH(8),
    .TX_ADDR   (8'hFC),
    .STAT_ADDR (8'hFD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RegData  (RegData),
    .Address  (Address),
    .EN       (EN),
    .UART_TXD (UART_TXD),
    .Status   (Status),
    .Last_Byte(Last_Byte)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [7:0] a, input logic [7:0] d);
    EN      = en;
    Address = a;
    RegData = d;
  endtask

  // Expected line level at position pos (0..79) of a frame carrying b
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos < 8) return 1'b0;
    else if (pos < 72) return b[3'((pos - 8) / 8)];
    else return 1'b1;
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    step();
    step();
    check_val("rst_txd", 32'(UART_TXD), 32'd1);
    check_val("rst_status", 32'(Status), 32'h00);
    check_val("rst_last", 32'(Last_Byte), 32'h00);
    rst = 1'b0;
    repeat (3) step();
    check_val("idle_status", 32'(Status), 32'h00);

    // Single byte A5
    drive(1'b1, 8'hFC, 8'hA5);
    step();
    drive(1'b0, 8'h00, 8'h00);
    check_val("a5_last", 32'(Last_Byte), 32'hA5);
    check_val("a5_status_push", 32'(Status), 32'h09);
    for (int k = 1; k <= 81; k++) begin
      step();
      if (k <= 80) begin
        check_val("a5_txd", 32'(UART_TXD), 32'(frame_bit(8'hA5, k - 1)));
        check_val("a5_busy", 32'(Status), 32'h01);
      end else begin
        check_val("a5_txd_idle", 32'(UART_TXD), 32'd1);
        check_val("a5_done", 32'(Status), 32'h00);
      end
    end
    repeat (4) step();

`ifndef UART_WR_EDGE_EN
    // Ten back-to-back writes, overflow, mid-stream clear, nine chained frames
    for (int k = 0; k <= 725; k++) begin
      int pops, cnt, f;
      logic ovf, busy, etxd;
      if (k <= 9) drive(1'b1, 8'hFC, 8'(k));
      else if (k == 150) drive(1'b1, 8'hFD, 8'hFF);
      else drive(1'b0, 8'h00, 8'h00);
      step();
      if (k >= 9) begin
        pops = (k - 1) / 80 + 1;
        if (pops > 9) pops = 9;
        cnt  = 9 - pops;
        ovf  = (k < 150);
        busy = (k <= 720);
        f    = (k - 1) / 80;
        etxd = (f <= 8) ? frame_bit(8'(f), (k - 1) % 80) : 1'b1;
        check_val("burst_txd", 32'(UART_TXD), 32'(etxd));
        check_val("burst_status", 32'(Status),
                  32'({1'b0, 4'(cnt), ovf, (cnt == 8), busy}));
      end
      if (k == 9) check_val("burst_last", 32'(Last_Byte), 32'h08);
    end
    drive(1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif

    // Reset during DATA bit 3 with three bytes queued
    for (int k = 0; k <= 36; k++) begin
      if (k == 0) drive(1'b1, 8'hFC, 8'h11);
      else if (k == 2) drive(1'b1, 8'hFC, 8'h22);
      else if (k == 4) drive(1'b1, 8'hFC, 8'h33);
      else if (k == 6) drive(1'b1, 8'hFC, 8'h44);
      else drive(1'b0, 8'h00, 8'h00);
      if (k == 36) rst = 1'b1;
      step();
      if (k == 6) check_val("q3_status", 32'(Status), 32'h19);
      if (k == 6) check_val("q3_last", 32'(Last_Byte), 32'h44);
      if (k == 35) check_val("bit3_txd", 32'(UART_TXD), 32'd0);
    end
    check_val("abort_txd", 32'(UART_TXD), 32'd1);
    check_val("abort_status", 32'(Status), 32'h00);
    check_val("abort_last", 32'(Last_Byte), 32'h00);
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      check_val("abort_quiet", 32'(UART_TXD), 32'd1);
    end
    check_val("abort_end_status", 32'(Status), 32'h00);

    // EN held high for 20 clocks at TX_ADDR with 3C
    for (int k = 0; k <= 200; k++) begin
      if (k <= 19) drive(1'b1, 8'hFC, 8'h3C);
      else drive(1'b0, 8'h00, 8'h00);
      step();
      if (k >= 1 && k <= 80)
        check_val("hold_txd", 32'(UART_TXD), 32'(frame_bit(8'h3C, k - 1)));
`ifdef UART_WR_EDGE_EN
      check_val("hold_cnt_le1", 32'(Status[6:3] <= 4'd1), 32'd1);
      check_val("hold_no_ovf", 32'(Status[2]), 32'd0);
      if (k == 19) check_val("hold_status19", 32'(Status), 32'h01);
      if (k > 80) check_val("hold_one_frame", 32'(UART_TXD), 32'd1);
      if (k == 81) check_val("hold_done", 32'(Status), 32'h00);
`else
      if (k == 19) check_val("hold_status19", 32'(Status), 32'h47);
`endif
      if (k == 19) check_val("hold_last", 32'(Last_Byte), 32'h3C);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
